// File: rtl/mode_request_gen.sv
// Debounced front-panel buttons -> single-cycle, mutually exclusive mode set pulses.
// Define MODE_REQ_CYCLE_EN to add a btn_cycle_i input that steps to the next mode.
module mode_request_gen #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned HOLDOFF_CYCLES  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_edit_i,
   input  logic       btn_play_i,
   input  logic       btn_raw_i,
`ifdef MODE_REQ_CYCLE_EN
   input  logic       btn_cycle_i,
`endif
   input  logic [1:0] mode_i,
   output logic       set_edit_o,
   output logic       set_play_o,
   output logic       set_raw_o,
   output logic       req_dropped_o
);

`ifdef MODE_REQ_CYCLE_EN
   localparam int unsigned NumBtn = 4;
`else
   localparam int unsigned NumBtn = 3;
`endif
   localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned HoW  = $clog2(HOLDOFF_CYCLES + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   logic [NumBtn-1:0]           btn_raw;
   logic [NumBtn-1:0]           meta_q, sync_q;
   logic [NumBtn-1:0]           stable_q, stable_d, stable_dly_q;
   logic [NumBtn-1:0][CntW-1:0] cnt_q, cnt_d;
   logic [NumBtn-1:0]           press, win_oh;
   logic [HoW-1:0]              ho_q, ho_d;
   logic [2:0]                  set_q, set_d;
   logic                        drop_q, drop_d;
   logic [1:0]                  tgt;

`ifdef MODE_REQ_CYCLE_EN
   assign btn_raw = {btn_cycle_i, btn_raw_i, btn_play_i, btn_edit_i};
`else
   assign btn_raw = {btn_raw_i, btn_play_i, btn_edit_i};
`endif

   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      for (int unsigned i = 0; i < NumBtn; i++) begin
         if (sync_q[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CntMax) begin
            stable_d[i] = sync_q[i];
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
         end
      end
   end

   assign press  = stable_q & ~stable_dly_q;
   // Lowest set bit is the highest-priority pending press.
   assign win_oh = press & (~press + NumBtn'(1));

   always_comb begin
      set_d  = '0;
      drop_d = 1'b0;
      ho_d   = ho_q;
      tgt    = 2'd0;
      if (press[0]) begin
         tgt = 2'd0;
      end else if (press[1]) begin
         tgt = 2'd1;
      end else if (press[2]) begin
         tgt = 2'd2;
`ifdef MODE_REQ_CYCLE_EN
      end else begin
         unique case (mode_i)
            2'd0:    tgt = 2'd1;
            2'd1:    tgt = 2'd2;
            default: tgt = 2'd0;
         endcase
`endif
      end

      if (ho_q != '0) begin
         ho_d   = ho_q - HoW'(1);
         drop_d = |press;
      end else if (|press) begin
         drop_d = |(press & ~win_oh);
         // A request for the mode already active is silently absorbed.
         if (tgt != mode_i) begin
            ho_d = HoW'(HOLDOFF_CYCLES);
            unique case (tgt)
               2'd0:    set_d = 3'b001;
               2'd1:    set_d = 3'b010;
               default: set_d = 3'b100;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q       <= '0;
         sync_q       <= '0;
         stable_q     <= '0;
         stable_dly_q <= '0;
         cnt_q        <= '0;
         ho_q         <= '0;
         set_q        <= '0;
         drop_q       <= 1'b0;
      end else begin
         meta_q       <= btn_raw;
         sync_q       <= meta_q;
         stable_q     <= stable_d;
         stable_dly_q <= stable_q;
         cnt_q        <= cnt_d;
         ho_q         <= ho_d;
         set_q        <= set_d;
         drop_q       <= drop_d;
      end
   end

   assign set_edit_o    = set_q[0];
   assign set_play_o    = set_q[1];
   assign set_raw_o     = set_q[2];
   assign req_dropped_o = drop_q;

endmodule

// File: doc/mode_request_gen.md
Name: mode_request_gen

Overview:
- Front end that drives the mode controller's command strobes: `set_edit`, `set_play`, `set_raw`.
- Takes raw front-panel mode buttons, synchronises and debounces them, and detects presses.
- Converts presses into single-cycle, mutually exclusive set pulses.
- Consumes the controller's current `mode` as feedback so it can suppress redundant requests and, optionally, support a cycle button.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronised button level must differ from the stable level before being accepted (>=2).
- HOLDOFF_CYCLES, 4, cycles after an issued pulse during which new presses are dropped (>=1).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- btn_edit  input  1  raw asynchronous button, high = pressed
- btn_play  input  1  raw asynchronous button, high = pressed
- btn_raw  input  1  raw asynchronous button, high = pressed
- mode  input  2  current mode from controller: 0 EDIT, 1 PLAY, 2 RAW, 3 illegal
- set_edit  output  1  one-cycle request pulse to EDIT
- set_play  output  1  one-cycle request pulse to PLAY
- set_raw  output  1  one-cycle request pulse to RAW
- req_dropped  output  1  one-cycle pulse when a detected press is discarded

Behaviour:
- Reset (rst_n low, async):
  - All outputs 0.
  - Sync flops 0, debounced levels 0, debounce counters 0, holdoff counter 0.
- Per-button pipeline:
  - 2-flop synchroniser produces `s`.
  - Stable level `d` with counter `c`:
    - If s==d: c<=0.
    - Else if c==DEBOUNCE_CYCLES-1: d<=s, c<=0.
    - Else: c<=c+1.
  - Press event = d rises, registered (`d & ~d_q`).
- Latency:
  - Clean press held high → set pulse asserted exactly DEBOUNCE_CYCLES+3 rising edges after the first edge sampling btn high.
- Glitches:
  - A low level shorter than DEBOUNCE_CYCLES cycles during a press produces no event; the counter restarts.
- Release:
  - Generates no request.
  - A press is detected again only after a debounced release.
- Arbitration (per cycle, registered outputs):
  - Candidate events, priority edit > play > raw.
  - At most one set_* high per cycle.
  - Simultaneous lower-priority events are discarded and pulse req_dropped.
- Redundancy suppression:
  - If the winning target equals `mode`, no set pulse is issued and no holdoff starts.
  - This case does not pulse req_dropped.
- Holdoff:
  - Issuing a pulse loads the holdoff counter with HOLDOFF_CYCLES.
  - The counter decrements each cycle to 0.
  - While nonzero, all new events are discarded and pulse req_dropped.
  - Debounce continues during holdoff, so a press that matures during holdoff is lost, not queued.
- mode==3 is treated as "no matching mode": every target is non-redundant.
- Held button: exactly one pulse per debounced press regardless of hold duration.
- Reset mid-debounce or mid-holdoff: all state clears immediately; the button must re-qualify for the full DEBOUNCE_CYCLES after rst_n rises.
- Counter widths: $clog2(DEBOUNCE_CYCLES) and $clog2(HOLDOFF_CYCLES+1).
  - No wrap: debounce counter never exceeds DEBOUNCE_CYCLES-1.

Optional Feature:
- MODE_REQ_CYCLE_EN defined:
  - Adds input port `btn_cycle` (1 bit, raw, same sync/debounce pipeline).
  - Lowest arbitration priority.
  - Its press targets next mode from `mode`: 0→PLAY, 1→RAW, 2→EDIT, 3→EDIT.
  - Never redundant.
  - Subject to holdoff and drop rules like other buttons.
- Undefined:
  - No `btn_cycle` port, no cycle logic.
  - Behaviour identical to the above without it.

Test Plan:
- Use DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=4.
- Reset:
  - rst_n low with all buttons high → outputs 0.
  - Release reset, buttons held → set_edit pulses once, 7 cycles after release.
- mode=0, btn_play held 20 cycles → set_play high for exactly 1 cycle at edge 7; no further pulses; release and re-press → second single pulse.
- mode=1, btn_play press → no set pulse, req_dropped stays 0.
- Glitch: btn_raw high 3 cycles, low 1, high 2, low → no pulse; then clean 10-cycle press → set_raw at edge 7.
- Simultaneous btn_edit and btn_raw rising same cycle, mode=1 → set_edit pulse, req_dropped pulse same cycle, no set_raw.
- Holdoff: set_edit issued; btn_play press maturing 2 cycles later → no set_play, req_dropped pulse.
- With MODE_REQ_CYCLE_EN: mode=2, btn_cycle press → set_edit; mode=3 → set_edit; mode=0 → set_play.
